// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM write arbiter.
//   state_t      : arbiter FSM state (IDLE, LOCKED)
//   grant_width  : width of a requester index, never less than 1
package vram_arb_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE   = 1'b0;
  localparam state_t LOCKED = 1'b1;

  function automatic int unsigned grant_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker.
//   req    : request vector, one bit per requester
//   rr_ptr : index that has highest priority this round
//   found  : at least one request is set
//   index  : first set request scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
module rr_priority_picker
  import vram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned GRANT_W = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               found,
  output logic [GRANT_W-1:0] index
);

  int unsigned        pos;
  logic [GRANT_W-1:0] pos_idx;

  // Scan from the farthest offset down so the nearest set request is written last.
  always_comb begin
    found   = 1'b0;
    index   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      pos     = (32'(rr_ptr) + 32'(off)) % NUM_REQ;
      pos_idx = GRANT_W'(pos);
      if (req[pos_idx]) begin
        found = 1'b1;
        index = pos_idx;
      end
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares one write-FIFO enqueue port among NUM_REQ requesters with rotating priority
// and a burst lock of up to BURST_LEN beats per grant. A one-entry output register
// drives the FIFO; FIFO back-pressure stalls the granted requester.
//   clock, reset_n       : system clock, asynchronous active-low reset
//   io_req_valid/ready   : per-requester beat handshake (ready is one-hot or zero)
//   io_req_addr/din/mask : packed per-requester payload, requester i at slot i
//   io_enq_valid/ready   : output beat handshake to the FIFO (ready = not full)
//   io_enq_addr/din/mask : registered output payload
//   io_grant             : current or last granted requester
//   io_busy              : FSM locked or an output beat pending
module vram_write_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MASK_WIDTH = 4,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               io_req_valid,
  output logic [NUM_REQ-1:0]               io_req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    io_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    io_req_din,
  input  logic [NUM_REQ*MASK_WIDTH-1:0]    io_req_mask,
  output logic                             io_enq_valid,
  input  logic                             io_enq_ready,
  output logic [ADDR_WIDTH-1:0]            io_enq_addr,
  output logic [DATA_WIDTH-1:0]            io_enq_din,
  output logic [MASK_WIDTH-1:0]            io_enq_mask,
  output logic [grant_width(NUM_REQ)-1:0]  io_grant,
  output logic                             io_busy
);

  localparam int unsigned GRANT_W = grant_width(NUM_REQ);
  localparam int unsigned CNT_W   = $clog2(BURST_LEN) + 1;

  state_t             state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic               pick_found;
  logic [GRANT_W-1:0] pick_index;
  logic               slot_free;
  logic               accept;
  logic               last_beat;
  logic [GRANT_W-1:0] grant_next;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_picker (
    .req    (io_req_valid),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .index  (pick_index)
  );

  // The output slot can take a new beat when empty or when it drains this cycle.
  always_comb begin
    slot_free    = ~io_enq_valid | io_enq_ready;
    io_req_ready = '0;
    if (state_q == LOCKED) begin
      io_req_ready[grant_q] = slot_free;
    end
    accept     = (state_q == LOCKED) & io_req_valid[grant_q] & slot_free;
    last_beat  = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
    grant_next = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        grant_d    = pick_index;
        beat_cnt_d = '0;
        state_d    = LOCKED;
      end
    end else begin
      if (accept) begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
      if (!io_req_valid[grant_q] || (accept && last_beat)) begin
        state_d  = IDLE;
        rr_ptr_d = grant_next;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Output register: loads on accept, holds while the FIFO is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_enq_valid <= 1'b0;
      io_enq_addr  <= '0;
      io_enq_din   <= '0;
      io_enq_mask  <= '0;
    end else if (accept) begin
      io_enq_valid <= 1'b1;
      io_enq_addr  <= io_req_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
      io_enq_din   <= io_req_din[grant_q*DATA_WIDTH +: DATA_WIDTH];
      io_enq_mask  <= io_req_mask[grant_q*MASK_WIDTH +: MASK_WIDTH];
    end else if (io_enq_ready) begin
      io_enq_valid <= 1'b0;
    end
  end

  assign io_grant = grant_q;
  assign io_busy  = (state_q != IDLE) | io_enq_valid;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed and randomized self-checking bench for vram_write_arbiter (3 requesters,
// burst length 8). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
module tb_vram_write_arbiter;

  localparam int NR = 3;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int MW = 4;

  logic              clock;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_din;
  logic [NR*MW-1:0]  req_mask;
  logic              enq_valid;
  logic              enq_ready;
  logic [AW-1:0]     enq_addr;
  logic [DW-1:0]     enq_din;
  logic [MW-1:0]     enq_mask;
  logic [1:0]        grant;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  vram_write_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MASK_WIDTH (MW),
    .BURST_LEN  (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .io_req_valid (req_valid),
    .io_req_ready (req_ready),
    .io_req_addr  (req_addr),
    .io_req_din   (req_din),
    .io_req_mask  (req_mask),
    .io_enq_valid (enq_valid),
    .io_enq_ready (enq_ready),
    .io_enq_addr  (enq_addr),
    .io_enq_din   (enq_din),
    .io_enq_mask  (enq_mask),
    .io_grant     (grant),
    .io_busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [MW-1:0] m);
    req_addr[i*AW +: AW] = a;
    req_din[i*DW +: DW]  = d;
    req_mask[i*MW +: MW] = m;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_din   = '0;
    req_mask  = '0;
    enq_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Payload for stress beat s of requester i: {addr, mask, din}.
  function automatic logic [AW+MW+DW-1:0] beat_word(input int i, input int unsigned s);
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    a = {2'(i), 15'(s)};
    m = 4'(s) ^ 4'(i);
    d = {8'(i), 24'(s)};
    return {a, m, d};
  endfunction

  // FIFO-side monitor: a beat transfers on the next rising edge when valid & ready.
  int            fifo_cnt = 0;
  logic [DW-1:0] got_din[$];
  bit            stress_on = 0;
  int unsigned   exp_seq[NR];

  always @(negedge clock) begin
    if (enq_valid && enq_ready) begin
      fifo_cnt++;
      got_din.push_back(enq_din);
      if (stress_on) begin
        int id;
        id = int'(enq_din[31:24]);
        if (id >= NR) begin
          check("stress_id", 64'(id), 64'(0));
        end else begin
          check("stress_beat", 64'({enq_addr, enq_mask, enq_din}),
                64'(beat_word(id, exp_seq[id])));
          exp_seq[id]++;
        end
      end
    end
  end

  int unsigned seq[NR];
  logic [NR-1:0] acc;

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_din   = '0;
    req_mask  = '0;
    enq_ready = 1'b1;

    // Reset state
    do_reset();
    @(negedge clock);
    check("rst_enq_valid", 64'(enq_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_enq_addr", 64'(enq_addr), 64'(0));

    // 1: single 3-beat burst from requester 0
    tick();
    req_valid = 3'b001;
    set_beat(0, 17'h100, 32'hA000_0000, 4'hF);
    @(negedge clock);
    check("t1_idle_ready", 64'(req_ready), 64'(0));
    tick();
    @(negedge clock);
    check("t1_ready_n1", 64'(req_ready), 64'(3'b001));
    check("t1_enqv_n1", 64'(enq_valid), 64'(0));
    check("t1_grant", 64'(grant), 64'(0));
    tick();
    set_beat(0, 17'h101, 32'hA000_0001, 4'h3);
    @(negedge clock);
    check("t1_enqv_n2", 64'(enq_valid), 64'(1));
    check("t1_addr_n2", 64'(enq_addr), 64'(17'h100));
    check("t1_mask_n2", 64'(enq_mask), 64'(4'hF));
    tick();
    set_beat(0, 17'h102, 32'hA000_0002, 4'h1);
    @(negedge clock);
    check("t1_addr_n3", 64'(enq_addr), 64'(17'h101));
    check("t1_mask_n3", 64'(enq_mask), 64'(4'h3));
    tick();
    req_valid = 3'b000;
    @(negedge clock);
    check("t1_addr_n4", 64'(enq_addr), 64'(17'h102));
    check("t1_enqv_n4", 64'(enq_valid), 64'(1));
    check("t1_busy_n4", 64'(busy), 64'(1));
    tick();
    @(negedge clock);
    check("t1_enqv_n5", 64'(enq_valid), 64'(0));
    check("t1_busy_n5", 64'(busy), 64'(0));
    check("t1_ready_n5", 64'(req_ready), 64'(0));

    // 2: three continuous requesters, 8-beat bursts with one idle cycle between
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 36; k++) begin
      logic [2:0] exp_rdy;
      @(negedge clock);
      exp_rdy = (k % 9 == 0) ? 3'b000 : 3'(1 << ((k / 9) % 3));
      check("t2_ready", 64'(req_ready), 64'(exp_rdy));
      if (k % 9 == 4) check("t2_grant", 64'(grant), 64'((k / 9) % 3));
      tick();
    end

    // 3: FIFO full for 5 cycles with a pending beat
    do_reset();
    fifo_cnt = 0;
    got_din.delete();
    req_valid = 3'b001;
    set_beat(0, 17'h200, 32'hDEAD_BEEF, 4'hA);
    tick();
    tick();
    set_beat(0, 17'h201, 32'h1111_1111, 4'h5);
    enq_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      check("t3_stall_din", 64'(enq_din), 64'(32'hDEAD_BEEF));
      check("t3_stall_addr", 64'(enq_addr), 64'(17'h200));
      check("t3_stall_ready", 64'(req_ready), 64'(0));
      check("t3_stall_valid", 64'(enq_valid), 64'(1));
      tick();
    end
    enq_ready = 1'b1;
    @(negedge clock);
    check("t3_resume_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = 3'b000;
    @(negedge clock);
    check("t3_second_din", 64'(enq_din), 64'(32'h1111_1111));
    tick();
    tick();
    check("t3_fifo_cnt", 64'(fifo_cnt), 64'(2));
    if (got_din.size() == 2) begin
      check("t3_first_din", 64'(got_din[0]), 64'(32'hDEAD_BEEF));
      check("t3_last_din", 64'(got_din[1]), 64'(32'h1111_1111));
    end else begin
      check("t3_fifo_depth", 64'(got_din.size()), 64'(2));
    end

    // 4: requester 1 drops after 2 beats, grant passes to 2, then rr_ptr wraps to 0
    do_reset();
    req_valid = 3'b110;
    tick();
    @(negedge clock);
    check("t4_ready_r1", 64'(req_ready), 64'(3'b010));
    tick();
    tick();
    req_valid = 3'b100;
    tick();
    @(negedge clock);
    check("t4_idle_ready", 64'(req_ready), 64'(0));
    tick();
    @(negedge clock);
    check("t4_ready_r2", 64'(req_ready), 64'(3'b100));
    check("t4_grant_r2", 64'(grant), 64'(2));
    tick();
    req_valid = 3'b000;
    tick();
    req_valid = 3'b111;
    tick();
    @(negedge clock);
    check("t4_wrap_grant", 64'(grant), 64'(0));
    check("t4_wrap_ready", 64'(req_ready), 64'(3'b001));

    // 5: asynchronous reset in the middle of a burst
    do_reset();
    req_valid = 3'b001;
    tick();
    tick();
    @(negedge clock);
    check("t5_pre_valid", 64'(enq_valid), 64'(1));
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(enq_valid), 64'(0));
    check("t5_async_ready", 64'(req_ready), 64'(0));
    req_valid = 3'b111;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("t5_post_grant", 64'(grant), 64'(0));
    check("t5_post_ready", 64'(req_ready), 64'(3'b001));

    // 6: random valid/ready stress against the monitor scoreboard
    do_reset();
    for (int i = 0; i < NR; i++) begin
      seq[i]     = 0;
      exp_seq[i] = 0;
    end
    acc       = '0;
    stress_on = 1;
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) seq[i]++;
        if (req_valid[i]) req_valid[i] = ($urandom_range(7) != 0);
        else req_valid[i] = ($urandom_range(1) != 0);
        {req_addr[i*AW +: AW], req_mask[i*MW +: MW], req_din[i*DW +: DW]} =
            beat_word(i, seq[i]);
      end
      enq_ready = ($urandom_range(3) != 0);
      @(negedge clock);
      acc = req_valid & req_ready;
      check("stress_onehot", 64'($onehot0(req_ready)), 64'(1));
    end
    tick();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) seq[i]++;
    end
    req_valid = '0;
    enq_ready = 1'b1;
    repeat (4) tick();
    stress_on = 0;
    for (int i = 0; i < NR; i++) begin
      check("stress_drain", 64'(exp_seq[i]), 64'(seq[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
